// File: rtl/hub75_pkg.sv
// Shared types and width helpers for the HUB75 scan controller.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_BLANK   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_DISPLAY = 3'd4
  } state_t;

  localparam int STATE_W = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Width of a counter/index that must represent values 0..n-1, never zero bits.
  function automatic int width_of(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int fb_addr_w(input int row_addr_w, input int cols);
    return row_addr_w + clog2(cols);
  endfunction

  // One counter serves both BLANK and DISPLAY, so it covers the larger of the two.
  function automatic int disp_cnt_w(input int base_ticks, input int color_bits, input int dead);
    int top;
    top = base_ticks << (color_bits - 1);
    if (dead > top) begin
      top = dead;
    end
    return width_of(top + 1);
  endfunction

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// Framebuffer read port between the scan controller (master) and the dual-bank framebuffer (slave).
interface hub75_scan_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 12
);

  // Fixed-latency read, no back-pressure: fb_rd_en is a one-cycle strobe with fb_addr valid in
  // the same cycle; fb_data_top/fb_data_bot must hold the addressed pixels exactly one cycle later.
  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data_top;
  logic [DATA_W-1:0] fb_data_bot;

  modport master (
    output fb_rd_en,
    output fb_addr,
    input  fb_data_top,
    input  fb_data_bot
  );

  modport slave (
    input  fb_rd_en,
    input  fb_addr,
    output fb_data_top,
    output fb_data_bot
  );

endinterface

// File: rtl/hub75_sclk_gen.sv
// Per-pixel phase counter: registered sclk and read strobe, plus capture and end-of-pixel strobes.
module hub75_sclk_gen
  import hub75_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run_q_i,
  input  logic run_d_i,
  output logic sclk_o,
  output logic rd_o,
  output logic cap_o,
  output logic pix_end_o
);

  localparam int PH_W = width_of(2 * CLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HIGH = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0] PH_CAP  = PH_W'(1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  logic [PH_W-1:0] phase_q;
  logic [PH_W-1:0] phase_d;
  logic            sclk_q;
  logic            rd_q;

  // Phase restarts at 0 on every entry into SHIFT, so each row starts on a fresh pixel.
  always_comb begin
    phase_d = '0;
    if (run_q_i && run_d_i) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= '0;
      sclk_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sclk_q  <= run_d_i && (phase_d >= PH_HIGH);
      rd_q    <= run_d_i && (phase_d == '0);
    end
  end

  assign sclk_o    = sclk_q;
  assign rd_o      = rd_q;
  assign cap_o     = run_q_i && (phase_q == PH_CAP);
  assign pix_end_o = run_q_i && (phase_q == PH_LAST);

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: shifts one BCM plane per row, blanks, latches, then displays it.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int COLS       = 32,
  parameter int ROW_ADDR_W = 4,
  parameter int COLOR_BITS = 4,
  parameter int CLK_DIV    = 2,
  parameter int BASE_TICKS = 8,
  parameter int DEAD       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  hub75_scan_ctrl_if.master     fb,
  output logic [ROW_ADDR_W-1:0] row_addr,
  output logic [2:0]            rgb0,
  output logic [2:0]            rgb1,
  output logic                  sclk,
  output logic                  lat,
  output logic                  oe_n,
  output logic                  frame_start,
  output state_t                dbg_state_o
);

  localparam int COL_W  = clog2(COLS);
  localparam int PL_W   = width_of(COLOR_BITS);
  localparam int CNT_W  = disp_cnt_w(BASE_TICKS, COLOR_BITS, DEAD);
  localparam int ADDR_W = fb_addr_w(ROW_ADDR_W, COLS);

  localparam logic [COL_W-1:0]      COL_LAST   = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0]      COL_ONE    = COL_W'(1);
  localparam logic [PL_W-1:0]       PL_LAST    = PL_W'(COLOR_BITS - 1);
  localparam logic [PL_W-1:0]       PL_ONE     = PL_W'(1);
  localparam logic [ROW_ADDR_W-1:0] ROW_ONE    = ROW_ADDR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      DEAD_LAST  = CNT_W'(DEAD - 1);
  localparam logic [CNT_W-1:0]      BASE_CNT   = CNT_W'(BASE_TICKS);

  state_t                  state_q, state_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_ADDR_W-1:0]   row_q, row_d;
  logic [PL_W-1:0]         plane_q, plane_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ROW_ADDR_W-1:0]   row_addr_q, row_addr_d;
  logic                    fs_d;

  logic [ADDR_W-1:0]       fb_addr_q;
  logic [2:0]              rgb0_q, rgb1_q;
  logic                    lat_q, oe_n_q, fs_q;

  logic                    run_q, run_d;
  logic                    sclk_w, rd_w, cap_w, pix_end_w;
  logic [CNT_W-1:0]        disp_last;

  logic [COLOR_BITS-1:0]   r_top, g_top, b_top;
  logic [COLOR_BITS-1:0]   r_bot, g_bot, b_bot;

  assign run_q     = (state_q == ST_SHIFT);
  assign run_d     = (state_d == ST_SHIFT);
  assign disp_last = (BASE_CNT << plane_q) - CNT_ONE;

  assign r_top = fb.fb_data_top[3*COLOR_BITS-1 -: COLOR_BITS];
  assign g_top = fb.fb_data_top[2*COLOR_BITS-1 -: COLOR_BITS];
  assign b_top = fb.fb_data_top[COLOR_BITS-1:0];
  assign r_bot = fb.fb_data_bot[3*COLOR_BITS-1 -: COLOR_BITS];
  assign g_bot = fb.fb_data_bot[2*COLOR_BITS-1 -: COLOR_BITS];
  assign b_bot = fb.fb_data_bot[COLOR_BITS-1:0];

  hub75_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .run_q_i   (run_q),
    .run_d_i   (run_d),
    .sclk_o    (sclk_w),
    .rd_o      (rd_w),
    .cap_o     (cap_w),
    .pix_end_o (pix_end_w)
  );

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    plane_d    = plane_q;
    cnt_d      = cnt_q;
    row_addr_d = row_addr_q;
    fs_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SHIFT;
          fs_d    = (row_q == '0) && (plane_q == '0);
        end
      end
      ST_SHIFT: begin
        if (pix_end_w) begin
          if (col_q == COL_LAST) begin
            col_d      = '0;
            cnt_d      = '0;
            // Row lines only move here, while the panel is guaranteed dark.
            row_addr_d = row_q;
            state_d    = ST_BLANK;
          end else begin
            col_d = col_q + COL_ONE;
          end
        end
      end
      ST_BLANK: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = ST_LATCH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LATCH: begin
        cnt_d   = '0;
        state_d = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        if (cnt_q == disp_last) begin
          cnt_d = '0;
          if (plane_q == PL_LAST) begin
            plane_d = '0;
            row_d   = row_q + ROW_ONE;
          end else begin
            plane_d = plane_q + PL_ONE;
          end
          // enable is only consulted here, so a plane is never cut short.
          state_d = enable ? ST_SHIFT : ST_IDLE;
          fs_d    = enable && (row_d == '0) && (plane_d == '0);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      plane_q    <= '0;
      cnt_q      <= '0;
      row_addr_q <= '0;
      fb_addr_q  <= '0;
      rgb0_q     <= '0;
      rgb1_q     <= '0;
      lat_q      <= 1'b0;
      oe_n_q     <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      plane_q    <= plane_d;
      cnt_q      <= cnt_d;
      row_addr_q <= row_addr_d;
      fb_addr_q  <= {row_d, col_d};
      lat_q      <= (state_d == ST_LATCH);
      oe_n_q     <= (state_d != ST_DISPLAY);
      fs_q       <= fs_d;
      // Read data arrives one cycle after the strobe; take the current plane bit of each channel.
      if (cap_w) begin
        rgb0_q <= {r_top[plane_q], g_top[plane_q], b_top[plane_q]};
        rgb1_q <= {r_bot[plane_q], g_bot[plane_q], b_bot[plane_q]};
      end
    end
  end

  assign fb.fb_rd_en = rd_w;
  assign fb.fb_addr  = fb_addr_q;
  assign row_addr    = row_addr_q;
  assign rgb0        = rgb0_q;
  assign rgb1        = rgb1_q;
  assign sclk        = sclk_w;
  assign lat         = lat_q;
  assign oe_n        = oe_n_q;
  assign frame_start = fs_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl on a 4x(2x2) panel with 2-bit colour.
module tb_hub75_scan_ctrl;
  import hub75_pkg::*;

  localparam int COLS       = 4;
  localparam int ROW_ADDR_W = 1;
  localparam int COLOR_BITS = 2;
  localparam int CLK_DIV    = 2;
  localparam int BASE_TICKS = 4;
  localparam int DEAD       = 2;
  localparam int AW         = 3;
  localparam int DW         = 6;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  logic [ROW_ADDR_W-1:0] row_addr;
  logic [2:0]            rgb0, rgb1;
  logic                  sclk, lat, oe_n, frame_start;
  state_t                dbg_state;

  hub75_scan_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) fb_if();

  hub75_scan_ctrl #(
    .COLS       (COLS),
    .ROW_ADDR_W (ROW_ADDR_W),
    .COLOR_BITS (COLOR_BITS),
    .CLK_DIV    (CLK_DIV),
    .BASE_TICKS (BASE_TICKS),
    .DEAD       (DEAD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fb          (fb_if),
    .row_addr    (row_addr),
    .rgb0        (rgb0),
    .rgb1        (rgb1),
    .sclk        (sclk),
    .lat         (lat),
    .oe_n        (oe_n),
    .frame_start (frame_start),
    .dbg_state_o (dbg_state)
  );

  // ---------------- framebuffer model (1-cycle read latency) ----------------
  logic [DW-1:0] top_mem [8];
  logic [DW-1:0] bot_mem [8];

  always @(posedge clk) begin
    if (fb_if.fb_rd_en) begin
      fb_if.fb_data_top <= top_mem[fb_if.fb_addr];
      fb_if.fb_data_bot <= bot_mem[fb_if.fb_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int         t;
    state_t     st;
    logic       sclk;
    logic       lat;
    logic       oe_n;
    logic       rd;
    logic       fs;
    logic [2:0] addr;
    logic       ra;
    logic [2:0] rgb0;
    logic [2:0] rgb1;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int t, input state_t st, input logic sc, input logic la, input logic oe,
                     input logic rd, input logic fs, input logic [2:0] ad, input logic ra,
                     input logic [2:0] c0, input logic [2:0] c1);
    vec_t v;
    v = '{t, st, sc, la, oe, rd, fs, ad, ra, c0, c1};
    tbl.push_back(v);
  endtask

  task automatic check_vec(input vec_t e);
    chk($sformatf("t%0d state", e.t), 32'(dbg_state), 32'(e.st));
    chk($sformatf("t%0d sclk", e.t), 32'(sclk), 32'(e.sclk));
    chk($sformatf("t%0d lat", e.t), 32'(lat), 32'(e.lat));
    chk($sformatf("t%0d oe_n", e.t), 32'(oe_n), 32'(e.oe_n));
    chk($sformatf("t%0d fb_rd_en", e.t), 32'(fb_if.fb_rd_en), 32'(e.rd));
    chk($sformatf("t%0d frame_start", e.t), 32'(frame_start), 32'(e.fs));
    chk($sformatf("t%0d fb_addr", e.t), 32'(fb_if.fb_addr), 32'(e.addr));
    chk($sformatf("t%0d row_addr", e.t), 32'(row_addr), 32'(e.ra));
    chk($sformatf("t%0d rgb0", e.t), 32'(rgb0), 32'(e.rgb0));
    chk($sformatf("t%0d rgb1", e.t), 32'(rgb1), 32'(e.rgb1));
  endtask

  // ---------------- stimulus ----------------
  int idx, lat_cnt, oe_low_cnt, rd_cnt, sclk_rise, fs0_cnt, fs_late_cnt, oe_drop_cnt, viol_cnt;
  int idle_sclk, idle_oe_low, idle_rd, idle_lat, idle_fs;
  logic prev_sclk;

  initial begin
    for (int i = 0; i < 8; i++) begin
      top_mem[i] = '0;
      bot_mem[i] = '0;
    end
    top_mem[1] = 6'b01_01_01;
    top_mem[2] = 6'b10_01_11;
    bot_mem[2] = 6'b01_11_00;
    top_mem[6] = 6'b11_00_10;
    bot_mem[6] = 6'b00_10_01;

    //  t    state       sclk lat  oe   rd   fs   addr  ra  rgb0    rgb1
    add(0,   ST_SHIFT,   0,   0,   1,   1,   1,   0,    0,  3'b000, 3'b000);
    add(1,   ST_SHIFT,   0,   0,   1,   0,   0,   0,    0,  3'b000, 3'b000);
    add(2,   ST_SHIFT,   1,   0,   1,   0,   0,   0,    0,  3'b000, 3'b000);
    add(4,   ST_SHIFT,   0,   0,   1,   1,   0,   1,    0,  3'b000, 3'b000);
    add(6,   ST_SHIFT,   1,   0,   1,   0,   0,   1,    0,  3'b111, 3'b000);
    add(8,   ST_SHIFT,   0,   0,   1,   1,   0,   2,    0,  3'b111, 3'b000);
    add(10,  ST_SHIFT,   1,   0,   1,   0,   0,   2,    0,  3'b011, 3'b110);
    add(12,  ST_SHIFT,   0,   0,   1,   1,   0,   3,    0,  3'b011, 3'b110);
    add(15,  ST_SHIFT,   1,   0,   1,   0,   0,   3,    0,  3'b000, 3'b000);
    add(16,  ST_BLANK,   0,   0,   1,   0,   0,   0,    0,  3'b000, 3'b000);
    add(18,  ST_LATCH,   0,   1,   1,   0,   0,   0,    0,  3'b000, 3'b000);
    add(19,  ST_DISPLAY, 0,   0,   0,   0,   0,   0,    0,  3'b000, 3'b000);
    add(22,  ST_DISPLAY, 0,   0,   0,   0,   0,   0,    0,  3'b000, 3'b000);
    add(23,  ST_SHIFT,   0,   0,   1,   1,   0,   0,    0,  3'b000, 3'b000);
    add(33,  ST_SHIFT,   1,   0,   1,   0,   0,   2,    0,  3'b101, 3'b010);
    add(49,  ST_DISPLAY, 0,   0,   0,   0,   0,   0,    0,  3'b000, 3'b000);
    add(50,  ST_SHIFT,   0,   0,   1,   1,   0,   4,    0,  3'b000, 3'b000);
    add(60,  ST_SHIFT,   1,   0,   1,   0,   0,   6,    0,  3'b100, 3'b001);
    add(65,  ST_SHIFT,   1,   0,   1,   0,   0,   7,    0,  3'b000, 3'b000);
    add(66,  ST_BLANK,   0,   0,   1,   0,   0,   4,    1,  3'b000, 3'b000);
    add(68,  ST_LATCH,   0,   1,   1,   0,   0,   4,    1,  3'b000, 3'b000);
    add(69,  ST_DISPLAY, 0,   0,   0,   0,   0,   4,    1,  3'b000, 3'b000);
    add(99,  ST_DISPLAY, 0,   0,   0,   0,   0,   4,    1,  3'b000, 3'b000);
    add(100, ST_SHIFT,   0,   0,   1,   1,   1,   0,    1,  3'b000, 3'b000);
    add(116, ST_BLANK,   0,   0,   1,   0,   0,   0,    0,  3'b000, 3'b000);
    add(142, ST_DISPLAY, 0,   0,   0,   0,   0,   0,    0,  3'b000, 3'b000);
    add(149, ST_DISPLAY, 0,   0,   0,   0,   0,   0,    0,  3'b000, 3'b000);
    add(150, ST_IDLE,    0,   0,   1,   0,   0,   4,    0,  3'b000, 3'b000);
    add(159, ST_IDLE,    0,   0,   1,   0,   0,   4,    0,  3'b000, 3'b000);
    add(160, ST_SHIFT,   0,   0,   1,   1,   0,   4,    0,  3'b000, 3'b000);
    add(170, ST_SHIFT,   1,   0,   1,   0,   0,   6,    0,  3'b100, 3'b001);
    add(176, ST_BLANK,   0,   0,   1,   0,   0,   4,    1,  3'b000, 3'b000);
    add(178, ST_LATCH,   0,   1,   1,   0,   0,   4,    1,  3'b000, 3'b000);
    add(182, ST_DISPLAY, 0,   0,   0,   0,   0,   4,    1,  3'b000, 3'b000);
    add(183, ST_SHIFT,   0,   0,   1,   1,   0,   4,    1,  3'b000, 3'b000);

    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3,
              3'd4, 3'd5, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};

    // Reset / idle
    rst = 1'b0;
    enable = 1'b0;
    repeat (5) step();
    chk("rst state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst sclk", 32'(sclk), 32'd0);
    chk("rst lat", 32'(lat), 32'd0);
    chk("rst oe_n", 32'(oe_n), 32'd1);
    chk("rst fb_rd_en", 32'(fb_if.fb_rd_en), 32'd0);
    chk("rst frame_start", 32'(frame_start), 32'd0);
    chk("rst row_addr", 32'(row_addr), 32'd0);
    chk("rst rgb0", 32'(rgb0), 32'd0);
    chk("rst rgb1", 32'(rgb1), 32'd0);
    rst = 1'b1;
    idle_sclk = 0; idle_oe_low = 0; idle_rd = 0; idle_lat = 0; idle_fs = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (sclk) idle_sclk++;
      if (!oe_n) idle_oe_low++;
      if (fb_if.fb_rd_en) idle_rd++;
      if (lat) idle_lat++;
      if (frame_start) idle_fs++;
    end
    chk("idle sclk_high_cycles", 32'(idle_sclk), 32'd0);
    chk("idle oe_low_cycles", 32'(idle_oe_low), 32'd0);
    chk("idle rd_cycles", 32'(idle_rd), 32'd0);
    chk("idle lat_cycles", 32'(idle_lat), 32'd0);
    chk("idle fs_cycles", 32'(idle_fs), 32'd0);
    chk("idle state", 32'(dbg_state), 32'(ST_IDLE));

    // Frame timing, pixel data, addressing and enable drop/resume
    idx = 0; lat_cnt = 0; oe_low_cnt = 0; rd_cnt = 0; sclk_rise = 0;
    fs0_cnt = 0; fs_late_cnt = 0; oe_drop_cnt = 0; viol_cnt = 0;
    prev_sclk = 1'b0;
    enable = 1'b1;
    for (int t = 0; t <= 190; t++) begin
      step();
      if (idx < tbl.size() && tbl[idx].t == t) begin
        check_vec(tbl[idx]);
        idx++;
      end
      if (lat && !oe_n) viol_cnt++;
      if (sclk && lat) viol_cnt++;
      if (t < 100) begin
        if (lat) lat_cnt++;
        if (!oe_n) oe_low_cnt++;
        if (sclk && !prev_sclk) sclk_rise++;
        if (frame_start) fs0_cnt++;
        if (fb_if.fb_rd_en) begin
          rd_cnt++;
          if (exp_q.size() != 0) chk($sformatf("t%0d rd_addr", t), 32'(fb_if.fb_addr), 32'(exp_q.pop_front()));
        end
      end
      if (t >= 101 && frame_start) fs_late_cnt++;
      if (t >= 140 && t < 160 && !oe_n) oe_drop_cnt++;
      prev_sclk = sclk;
      if (t == 144) enable = 1'b0;
      if (t == 159) enable = 1'b1;
    end
    chk("frame lat_pulses", 32'(lat_cnt), 32'd4);
    chk("frame oe_low_cycles", 32'(oe_low_cnt), 32'd24);
    chk("frame sclk_rises", 32'(sclk_rise), 32'd16);
    chk("frame rd_strobes", 32'(rd_cnt), 32'd16);
    chk("frame fs_pulses", 32'(fs0_cnt), 32'd1);
    chk("rd_addr leftover", 32'(exp_q.size()), 32'd0);
    chk("resume fs_pulses", 32'(fs_late_cnt), 32'd0);
    chk("drop oe_low_cycles", 32'(oe_drop_cnt), 32'd8);
    chk("invariant violations", 32'(viol_cnt), 32'd0);

    // Reset mid-SHIFT
    enable = 1'b0;
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    enable = 1'b1;
    step();
    chk("rs u0 frame_start", 32'(frame_start), 32'd1);
    repeat (6) step();
    chk("rs u6 sclk", 32'(sclk), 32'd1);
    chk("rs u6 rgb0", 32'(rgb0), 32'd7);
    rst = 1'b0;
    step();
    chk("rs u7 state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rs u7 sclk", 32'(sclk), 32'd0);
    chk("rs u7 oe_n", 32'(oe_n), 32'd1);
    chk("rs u7 fb_rd_en", 32'(fb_if.fb_rd_en), 32'd0);
    chk("rs u7 rgb0", 32'(rgb0), 32'd0);
    chk("rs u7 frame_start", 32'(frame_start), 32'd0);
    rst = 1'b1;
    step();
    chk("rs u8 state", 32'(dbg_state), 32'(ST_SHIFT));
    chk("rs u8 frame_start", 32'(frame_start), 32'd1);
    chk("rs u8 fb_rd_en", 32'(fb_if.fb_rd_en), 32'd1);
    chk("rs u8 fb_addr", 32'(fb_if.fb_addr), 32'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
- Parametrised HUB75 LED-matrix scan controller. It replaces the fixed clock-divider plus matrix pair with one block that has a generic row/column count, binary-coded-modulation (BCM) colour depth and a framebuffer read port.
- Sits between a dual-bank framebuffer (top and bottom panel halves) and the panel connector pins.
- Adds behaviour the previous driver lacked: per-pixel colour depth, dead-time blanking, enable/idle, and a frame-start strobe.

Parameters:
- COLS, 32, pixels shifted per row (power of two, ≥2)
- ROW_ADDR_W, 4, scan-row address width; scan rows = 2**ROW_ADDR_W (panel height = 2× that)
- COLOR_BITS, 4, bits per colour channel (BCM planes)
- CLK_DIV, 2, system cycles per shift-clock half period (≥2)
- BASE_TICKS, 8, display cycles for plane 0; plane b displays BASE_TICKS<<b
- DEAD, 2, blanking cycles before each latch

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- enable  in  1  scan enable
- fb_rd_en  out  1  framebuffer read strobe
- fb_addr  out  ROW_ADDR_W+log2(COLS)  {row, col}
- fb_data_top  in  3*COLOR_BITS  {R,G,B} of top-half pixel, valid 1 cycle after fb_rd_en
- fb_data_bot  in  3*COLOR_BITS  {R,G,B} of bottom-half pixel, same timing
- row_addr  out  ROW_ADDR_W  panel A/B/C/D… lines
- rgb0  out  3  {R0,G0,B0}
- rgb1  out  3  {R1,G1,B1}
- sclk  out  1  panel shift clock
- lat  out  1  latch, active-high
- oe_n  out  1  output enable, active-low
- frame_start  out  1  one-cycle pulse

Behaviour:
- Reset (rst=0 at a clk edge) forces the following on the next edge, including mid-operation, with no partial-plane completion: state=IDLE; row=0; plane=0; col=0; sclk=0; lat=0; oe_n=1; rgb0=rgb1=0; fb_rd_en=0; frame_start=0; row_addr=0.
- FSM states are IDLE, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE: oe_n=1. Go to SHIFT when enable=1. On entry to SHIFT with row=0 and plane=0, frame_start=1 for that cycle.
- SHIFT: each pixel occupies 2*CLK_DIV cycles.
  - Low phase: first cycle asserts fb_rd_en and drives fb_addr={row,col}. The second cycle registers rgb0/rgb1 = bit[plane] of each channel from fb_data_top/fb_data_bot. sclk=0 throughout the low phase.
  - High phase: sclk=1 for CLK_DIV cycles, with data stable.
  - After col=COLS-1 completes, col wraps to 0 and the FSM goes to BLANK. SHIFT lasts COLS*2*CLK_DIV cycles.
  - oe_n=1 throughout SHIFT.
- BLANK: oe_n=1 for DEAD cycles. row_addr is updated to row on the first BLANK cycle, and only while blanked. Then go to LATCH.
- LATCH: lat=1 for exactly one cycle, then DISPLAY.
- DISPLAY: oe_n=0 for BASE_TICKS<<plane cycles. At the end, oe_n returns to 1 and counters advance:
  - If plane < COLOR_BITS-1: plane++.
  - Otherwise plane=0 and row++; row wraps 2**ROW_ADDR_W-1 → 0.
- After DISPLAY: if enable=1, go to SHIFT; else go to IDLE. enable is sampled only at the end of DISPLAY, so deassertion mid-plane completes the current plane.
- Counter widths: the display counter must hold BASE_TICKS<<(COLOR_BITS-1) without overflow.
- fb_rd_en is high for one cycle per pixel; the framebuffer read latency is fixed at 1 cycle.
- Period per row = sum over b of (COLS*2*CLK_DIV + DEAD + 1 + (BASE_TICKS<<b)).
- Frame period = 2**ROW_ADDR_W × (period per row).
- Invariant: lat and oe_n=0 are never asserted in the same cycle. sclk=1 never coincides with lat=1.

Decomposition:
- Package hub75_pkg: FSM state enum, function clog2, localparam helpers for address width and display-counter width.
- One sub-module, hub75_sclk_gen: the CLK_DIV phase counter producing sclk, the low/high phase strobes and the end-of-pixel strobe.

Test Plan:
Bench parameters for all tests: COLS=4, ROW_ADDR_W=1, COLOR_BITS=2, CLK_DIV=2, BASE_TICKS=4, DEAD=2.
- Reset/idle: hold rst=0 for 5 cycles, enable=0 → all outputs at reset values, oe_n=1, no sclk toggles for 50 cycles.
- Frame timing: enable=1 → frame_start pulses exactly every 100 cycles. Per row, plane 0 oe_n low for 4 cycles and plane 1 for 8 cycles. lat high one cycle each, 4 per frame.
- Pixel data: framebuffer top pixel col2 row0 = R=2'b10, G=2'b01, B=2'b11 → on the 3rd sclk rising edge, rgb0 = 3'b011 in plane 0 and 3'b101 in plane 1. Bottom-half data checked likewise on rgb1.
- Row/addr: fb_addr sequence per plane is 0,1,2,3 (row 0) then 4,5,6,7 (row 1). row_addr changes 0→1 only while oe_n=1, in BLANK before the row-1 plane-0 latch.
- Enable drop: deassert enable during plane-1 DISPLAY → the 8-cycle display completes, then IDLE with oe_n=1. Reassert → resumes at row 1, plane 0 with no frame_start.
- Reset mid-SHIFT: rst=0 at cycle 7 after enable → the next edge gives sclk=0, oe_n=1, fb_rd_en=0. After release, the first frame_start occurs at the first SHIFT cycle.
